// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register-zero index and write-back source encoding
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef enum logic {SRC_PIPE = 1'b0, SRC_LONG = 1'b1} src_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: request, issue, operand and register-file write bundle
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic issue_ready;
  logic req0_valid;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic req0_ready;
  logic req1_valid;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic req1_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic rs_busy;
  logic rt_busy;
  logic hazard_stall;
  logic rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  modport master (
    output issue_valid, issue_reg, req0_valid, req0_reg, req0_data,
           req1_valid, req1_reg, req1_data, rs_addr, rt_addr,
    input  issue_ready, req0_ready, req1_ready, rs_busy, rt_busy, hazard_stall,
           rf_reg_write, rf_write_reg, rf_write_data
  );
  modport slave (
    input  issue_valid, issue_reg, req0_valid, req0_reg, req0_data,
           req1_valid, req1_reg, req1_data, rs_addr, rt_addr,
    output issue_ready, req0_ready, req1_ready, rs_busy, rt_busy, hazard_stall,
           rf_reg_write, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: 2-way round-robin grant; prio flips to the other side after any grant
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  src_e prio;
  assign grant[0] = valid[0] && (!valid[1] || prio == SRC_PIPE);
  assign grant[1] = valid[1] && (!valid[0] || prio == SRC_LONG);
  // pointer moves away from whoever was just served, holds when idle
  always_ff @(posedge clk)
    if (reset) prio <= SRC_PIPE;
    else if (|grant) prio <= grant[0] ? SRC_LONG : SRC_PIPE;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port and tracks long-latency destinations
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  regfile_wb_scheduler_if.slave b
);
  logic [1:0] grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [(1<<ADDR_W)-1:0] busy, busy_nxt;
  logic issue_set;
  src_e src;
  wb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({b.req1_valid, b.req0_valid}),
    .grant (grant)
  );
  assign b.req0_ready = grant[0];
  assign b.req1_ready = grant[1];
  assign sel_reg = grant[1] ? b.req1_reg : b.req0_reg;
  assign sel_data = grant[1] ? b.req1_data : b.req0_data;
  assign b.issue_ready = !busy[b.issue_reg];
  assign b.rs_busy = busy[b.rs_addr];
  assign b.rt_busy = busy[b.rt_addr];
  assign b.hazard_stall = b.rs_busy | b.rt_busy;
  assign issue_set = b.issue_valid && b.issue_ready && b.issue_reg != ADDR_W'(REG_ZERO);
  // clear on the committing edge of a long-latency write, set applied last so it wins
  always_comb begin
    busy_nxt = busy;
    if (b.rf_reg_write && src == SRC_LONG) busy_nxt[b.rf_write_reg] = 1'b0;
    if (issue_set) busy_nxt[b.issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  // scoreboard register
  always_ff @(posedge clk)
    if (reset) busy <= '0;
    else busy <= busy_nxt;
  // write port stage: load the granted request, drop the enable when idle
  always_ff @(posedge clk)
    if (reset) begin
      b.rf_reg_write <= 1'b0;
      b.rf_write_reg <= '0;
      b.rf_write_data <= '0;
      src <= SRC_PIPE;
    end else if (|grant) begin
      b.rf_reg_write <= sel_reg != ADDR_W'(REG_ZERO);
      b.rf_write_reg <= sel_reg;
      b.rf_write_data <= sel_data;
      src <= grant[1] ? SRC_LONG : SRC_PIPE;
    end else
      b.rf_reg_write <= 1'b0;
endmodule
